// File: rtl/edf_ic_pkg.sv
// Shared types and config-word layout for the EDF interrupt gateway array.
package edf_ic_pkg;

    typedef enum logic [1:0] {
        CH_IDLE      = 2'd0,
        CH_PENDING   = 2'd1,
        CH_INSERVICE = 2'd2
    } ch_state_e;

    // Config word: [OffsetWidth-1:0] offset, then the control/status bits below.
    localparam int unsigned CfgOffsetMaxWidth = 24;
    localparam int unsigned CfgIpBit          = 24;
    localparam int unsigned CfgIeBit          = 25;
    localparam int unsigned CfgTrigBit        = 26;
    localparam int unsigned CfgStateLsb       = 27;
    localparam int unsigned CfgStateMsb       = 28;

endpackage

// File: rtl/edf_gateway_ch.sv
// One interrupt channel: gateway FSM, arrival timestamp and saturating deadline.
module edf_gateway_ch
    import edf_ic_pkg::*;
#(
    parameter int TsWidth     = 64,
    parameter int OffsetWidth = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [TsWidth-1:0]     mtime_i,
    input  logic                   irq_i,
    input  logic                   cfg_we_i,
    input  logic [OffsetWidth-1:0] cfg_offset_i,
    input  logic                   cfg_ip_i,
    input  logic                   cfg_ie_i,
    input  logic                   cfg_trig_i,
    input  logic                   claim_i,
    input  logic                   complete_i,
    output ch_state_e              state_o,
    output logic                   ie_o,
    output logic                   trig_o,
    output logic [OffsetWidth-1:0] offset_o,
    output logic [TsWidth-1:0]     deadline_o
);

    ch_state_e              state_q;
    logic [TsWidth-1:0]     ts_q;
    logic [OffsetWidth-1:0] offset_q;
    logic                   ie_q;
    logic                   trig_q;
    logic                   irq_q;
    logic                   pend_again_q;
    logic                   rise;
    logic                   trigger;
    logic                   pend_cond;
    logic [TsWidth:0]       dl_sum;

    assign rise      = irq_i & ~irq_q;
    assign trigger   = ie_q & (trig_q ? rise : irq_i);
    // An edge arriving in the completion cycle itself also counts as a re-pend.
    assign pend_cond = trig_q ? (pend_again_q | rise) : irq_i;

    assign dl_sum     = {1'b0, ts_q} + (TsWidth + 1)'(offset_q);
    assign deadline_o = dl_sum[TsWidth] ? '1 : dl_sum[TsWidth-1:0];

    assign state_o  = state_q;
    assign ie_o     = ie_q;
    assign trig_o   = trig_q;
    assign offset_o = offset_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= CH_IDLE;
            ts_q         <= '0;
            offset_q     <= '0;
            ie_q         <= 1'b0;
            trig_q       <= 1'b0;
            irq_q        <= 1'b0;
            pend_again_q <= 1'b0;
        end else begin
            irq_q <= irq_i;
            if (cfg_we_i) begin
                offset_q <= cfg_offset_i;
                ie_q     <= cfg_ie_i;
                trig_q   <= cfg_trig_i;
            end
            case (state_q)
                CH_IDLE: begin
                    if ((cfg_we_i && cfg_ip_i) || trigger) begin
                        state_q <= CH_PENDING;
                        ts_q    <= mtime_i;
                    end
                end
                CH_PENDING: begin
                    if (claim_i) begin
                        state_q <= CH_INSERVICE;
                    end else if (cfg_we_i && !cfg_ip_i) begin
                        state_q <= CH_IDLE;
                    end
                end
                CH_INSERVICE: begin
                    if (complete_i) begin
                        pend_again_q <= 1'b0;
                        if (pend_cond) begin
                            state_q <= CH_PENDING;
                            ts_q    <= mtime_i;
                        end else begin
                            state_q <= CH_IDLE;
                        end
                    end else if (rise) begin
                        pend_again_q <= 1'b1;
                    end
                end
                default: state_q <= CH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/edf_gateway_array.sv
// Array of EDF interrupt gateways with config access and earliest-deadline selection.
// cfg_req_i, claim_i and complete_i are single-cycle strobes with no backpressure.
module edf_gateway_array
    import edf_ic_pkg::*;
#(
    parameter int NumCh       = 8,
    parameter int TsWidth     = 64,
    parameter int OffsetWidth = 24,
    localparam int IdWidth    = $clog2(NumCh)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [63:0]        mtime_i,
    input  logic [NumCh-1:0]   irq_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [IdWidth-1:0] cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic               claim_i,
    input  logic [IdWidth-1:0] claim_id_i,
    input  logic               complete_i,
    input  logic [IdWidth-1:0] complete_id_i,
    output logic [NumCh-1:0]   ip_o,
    output logic [NumCh-1:0]   is_o,
    output logic               best_valid_o,
    output logic [IdWidth-1:0] best_id_o,
    output logic [TsWidth-1:0] best_dl_o
);

    ch_state_e              state_a  [NumCh];
    logic                   ie_a     [NumCh];
    logic                   trig_a   [NumCh];
    logic [OffsetWidth-1:0] offset_a [NumCh];
    logic [TsWidth-1:0]     dl_a     [NumCh];

    logic                   sel_valid;
    logic [IdWidth-1:0]     sel_id;
    logic [TsWidth-1:0]     sel_dl;
    logic [31:0]            rd_word;
    logic                   unused_wdata;

    assign unused_wdata = ^cfg_wdata_i[31:27];

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        edf_gateway_ch #(
            .TsWidth     (TsWidth),
            .OffsetWidth (OffsetWidth)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .mtime_i      (mtime_i[TsWidth-1:0]),
            .irq_i        (irq_i[g]),
            .cfg_we_i     (cfg_req_i && cfg_we_i && (cfg_addr_i == IdWidth'(g))),
            .cfg_offset_i (cfg_wdata_i[OffsetWidth-1:0]),
            .cfg_ip_i     (cfg_wdata_i[CfgIpBit]),
            .cfg_ie_i     (cfg_wdata_i[CfgIeBit]),
            .cfg_trig_i   (cfg_wdata_i[CfgTrigBit]),
            .claim_i      (claim_i && (claim_id_i == IdWidth'(g))),
            .complete_i   (complete_i && (complete_id_i == IdWidth'(g))),
            .state_o      (state_a[g]),
            .ie_o         (ie_a[g]),
            .trig_o       (trig_a[g]),
            .offset_o     (offset_a[g]),
            .deadline_o   (dl_a[g])
        );
        assign ip_o[g] = (state_a[g] == CH_PENDING);
        assign is_o[g] = (state_a[g] == CH_INSERVICE);
    end

    // Strict less-than keeps the lowest index on equal deadlines.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        sel_dl    = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (state_a[i] == CH_PENDING && ie_a[i] && (!sel_valid || dl_a[i] < sel_dl)) begin
                sel_valid = 1'b1;
                sel_id    = IdWidth'(i);
                sel_dl    = dl_a[i];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (cfg_addr_i == IdWidth'(i)) begin
                rd_word[OffsetWidth-1:0]           = offset_a[i];
                rd_word[CfgIpBit]                  = (state_a[i] == CH_PENDING);
                rd_word[CfgIeBit]                  = ie_a[i];
                rd_word[CfgTrigBit]                = trig_a[i];
                rd_word[CfgStateMsb:CfgStateLsb]   = state_a[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_valid_o <= 1'b0;
            best_id_o    <= '0;
            best_dl_o    <= '0;
            cfg_rdata_o  <= '0;
        end else begin
            best_valid_o <= sel_valid;
            best_id_o    <= sel_id;
            best_dl_o    <= sel_dl;
            if (cfg_req_i && !cfg_we_i) begin
                cfg_rdata_o <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_edf_gateway_array.sv
// Directed bench for edf_gateway_array: EDF selection, gateway FSM, config and reset.
module tb_edf_gateway_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mtime = '0;
    logic [7:0]  irq = '0;
    logic        cfg_req = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        claim = 1'b0;
    logic [2:0]  claim_id = '0;
    logic        complete = 1'b0;
    logic [2:0]  complete_id = '0;
    logic [7:0]  ip;
    logic [7:0]  is_v;
    logic        best_valid;
    logic [2:0]  best_id;
    logic [63:0] best_dl;

    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad = 0;

    edf_gateway_array #(
        .NumCh       (8),
        .TsWidth     (64),
        .OffsetWidth (24)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mtime_i       (mtime),
        .irq_i         (irq),
        .cfg_req_i     (cfg_req),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_rdata_o   (cfg_rdata),
        .claim_i       (claim),
        .claim_id_i    (claim_id),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .ip_o          (ip),
        .is_o          (is_v),
        .best_valid_o  (best_valid),
        .best_id_o     (best_id),
        .best_dl_o     (best_dl)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // helpers and driver tasks
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int off, input bit ie, input bit trig, input bit ip_b);
        logic [31:0] w;
        w        = '0;
        w[23:0]  = off[23:0];
        w[24]    = ip_b;
        w[25]    = ie;
        w[26]    = trig;
        return w;
    endfunction

    function automatic logic [31:0] rdw(input int off, input bit ie, input bit trig, input int st);
        logic [31:0] w;
        w        = mk(off, ie, trig, st == 1);
        w[28:27] = st[1:0];
        return w;
    endfunction

    task automatic cfg_write(input int ch, input logic [31:0] w);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = ch[2:0];
        cfg_wdata = w;
        step();
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
    endtask

    // scoreboard: expected read data is queued when the read is issued
    task automatic cfg_read(input int ch, input logic [31:0] w, input string tag);
        logic [63:0] e;
        string       t;
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = ch[2:0];
        exp_q.push_back({32'd0, w});
        tag_q.push_back(tag);
        step();
        cfg_req  = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {32'd0, cfg_rdata}, e);
        end
    endtask

    task automatic do_claim(input int ch);
        claim    = 1'b1;
        claim_id = ch[2:0];
        step();
        claim    = 1'b0;
    endtask

    task automatic do_complete(input int ch);
        complete    = 1'b1;
        complete_id = ch[2:0];
        step();
        complete    = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_ip", ip, 0);
        chk("rst_is", is_v, 0);
        chk("rst_bv", best_valid, 0);
        chk("rst_bid", best_id, 0);
        chk("rst_bdl", best_dl, 0);
        chk("rst_rdata", cfg_rdata, 0);
        rst = 1'b0;
        step();

        // level channel 3 with offset 100
        cfg_write(3, mk(100, 1, 0, 0));
        mtime = 64'd1000;
        irq[3] = 1'b1;
        step();
        chk("lvl_ip", ip, 8'h08);
        chk("lvl_bv_lat", best_valid, 0);
        mtime = 64'd1001;
        step();
        chk("lvl_bv", best_valid, 1);
        chk("lvl_bid", best_id, 3);
        chk("lvl_bdl", best_dl, 64'd1100);
        cfg_read(3, rdw(100, 1, 0, 1), "rd_ch3");
        irq[3] = 1'b0;
        do_claim(3);
        chk("claim3_is", is_v, 8'h08);
        chk("claim3_ip", ip, 0);
        step();
        chk("claim3_bv", best_valid, 0);
        do_complete(3);
        chk("cmpl3_is", is_v, 0);
        chk("cmpl3_ip", ip, 0);

        // EDF ordering and tie-break
        mtime = 64'd100;
        cfg_write(1, mk(400, 1, 0, 1));
        cfg_write(5, mk(400, 1, 0, 1));
        cfg_write(2, mk(300, 1, 0, 1));
        step();
        chk("edf_ip", ip, 8'h26);
        chk("edf_bid", best_id, 2);
        chk("edf_bdl", best_dl, 64'd400);
        do_claim(2);
        step();
        chk("tie_bid", best_id, 1);
        chk("tie_bdl", best_dl, 64'd500);
        cfg_write(1, mk(400, 1, 0, 0));
        step();
        chk("swclr_bid", best_id, 5);
        cfg_write(5, mk(400, 1, 0, 0));
        do_complete(2);
        step();
        chk("edf_clean_ip", ip, 0);
        chk("edf_clean_is", is_v, 0);
        chk("edf_clean_bv", best_valid, 0);

        // deadline saturation and the no-carry neighbour
        mtime = 64'hFFFF_FFFF_FFFF_FFF6;
        cfg_write(6, mk(50, 1, 0, 1));
        step();
        chk("sat_bid", best_id, 6);
        chk("sat_bdl", best_dl, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_read(6, rdw(50, 1, 0, 1), "rd_ch6");
        cfg_write(6, mk(50, 1, 0, 0));
        mtime = 64'hFFFF_FFFF_FFFF_FF00;
        cfg_write(6, mk(16, 1, 0, 1));
        step();
        chk("nosat_bdl", best_dl, 64'hFFFF_FFFF_FFFF_FF10);
        cfg_write(6, mk(16, 1, 0, 0));

        // edge channel 0 with pend-again during service
        mtime = 64'd1500;
        cfg_write(0, mk(20, 1, 1, 0));
        irq[0] = 1'b1;
        step();
        chk("edge_ip", ip, 8'h01);
        irq[0] = 1'b0;
        do_claim(0);
        chk("edge_is", is_v, 8'h01);
        irq[0] = 1'b1;
        step();
        chk("edge_svc_is", is_v, 8'h01);
        chk("edge_svc_ip", ip, 0);
        mtime = 64'd2000;
        do_complete(0);
        chk("repend_ip", ip, 8'h01);
        chk("repend_is", is_v, 0);
        step();
        chk("repend_bid", best_id, 0);
        chk("repend_bdl", best_dl, 64'd2020);
        cfg_read(0, rdw(20, 1, 1, 1), "rd_ch0");
        cfg_write(0, mk(20, 1, 1, 0));
        irq[0] = 1'b0;
        step();
        chk("edge_clr_ip", ip, 0);
        irq[0] = 1'b1;
        step();
        chk("edge2_ip", ip, 8'h01);
        do_claim(0);
        do_complete(0);
        chk("edge_noagain_ip", ip, 0);
        chk("edge_noagain_is", is_v, 0);
        irq[0] = 1'b0;

        // claim beats config ip=0; ignored claim/complete/ip
        mtime = 64'd2500;
        cfg_write(4, mk(30, 1, 0, 1));
        claim    = 1'b1;
        claim_id = 3'd4;
        cfg_write(4, mk(30, 1, 0, 0));
        claim    = 1'b0;
        chk("prio_is", is_v, 8'h10);
        chk("prio_ip", ip, 0);
        do_claim(6);
        chk("idle_claim_is", is_v, 8'h10);
        chk("idle_claim_ip", ip, 0);
        cfg_write(4, mk(30, 1, 0, 1));
        chk("ip_in_svc", is_v, 8'h10);
        do_complete(6);
        chk("bad_cmpl_is", is_v, 8'h10);
        do_complete(4);
        chk("cmpl4_is", is_v, 0);
        cfg_write(5, mk(7, 0, 0, 1));
        step();
        chk("ie0_ip", ip, 8'h20);
        chk("ie0_bv", best_valid, 0);
        cfg_write(5, mk(7, 0, 0, 0));

        // asynchronous reset mid-operation
        mtime = 64'd3000;
        cfg_write(7, mk(10, 1, 0, 0));
        irq[7] = 1'b1;
        step();
        cfg_write(2, mk(5, 1, 0, 1));
        do_claim(2);
        step();
        chk("pre_rst_ip", ip, 8'h80);
        chk("pre_rst_is", is_v, 8'h04);
        chk("pre_rst_bid", best_id, 7);
        chk("pre_rst_bdl", best_dl, 64'd3010);
        cfg_read(7, rdw(10, 1, 0, 1), "rd_ch7_pre");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ip", ip, 0);
        chk("arst_is", is_v, 0);
        chk("arst_bv", best_valid, 0);
        chk("arst_bid", best_id, 0);
        chk("arst_bdl", best_dl, 0);
        chk("arst_rdata", cfg_rdata, 0);
        mtime = 64'd4000;
        step();
        step();
        rst = 1'b0;
        mtime = 64'd5000;
        step();
        chk("post_rst_ie0_ip", ip, 0);
        cfg_write(7, mk(10, 1, 0, 0));
        chk("post_cfg_ip", ip, 0);
        step();
        chk("post_pend_ip", ip, 8'h80);
        step();
        chk("post_bid", best_id, 7);
        chk("post_bdl", best_dl, 64'd5010);
        cfg_read(2, rdw(0, 0, 0, 0), "rd_ch2_post");
        cfg_read(7, rdw(10, 1, 0, 1), "rd_ch7_post");

        if (exp_q.size() != 0) chk("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edf_gateway_array.md
EDF_GATEWAY_ARRAY -- requirements
Module: edf_gateway_array

Interface
REQ-001 SHALL have parameter NumCh, default 8, number of IRQ channels (>=2).
REQ-002 SHALL have parameter TsWidth, default 64, timestamp/deadline width.
REQ-003 SHALL have parameter OffsetWidth, default 24, relative-deadline offset width (<=24).
REQ-004 SHALL have localparam IdWidth = $clog2(NumCh).
REQ-005 SHALL use one clock; reset is asynchronous and active-high: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-006 mtime_i  in  64  platform time.
REQ-007 irq_i  in  NumCh  raw interrupt lines.
REQ-008 cfg_req_i  in  1  config access strobe; cfg_we_i  in  1  write enable; cfg_addr_i  in  IdWidth  channel index.
REQ-009 cfg_wdata_i  in  32  write data; cfg_rdata_o  out  32  read data.
REQ-010 claim_i  in  1, claim_id_i  in  IdWidth: claim of a channel.
REQ-011 complete_i  in  1, complete_id_i  in  IdWidth: end of service of a channel.
REQ-012 ip_o  out  NumCh  pending vector; is_o  out  NumCh  in-service vector.
REQ-013 best_valid_o  out  1, best_id_o  out  IdWidth, best_dl_o  out  TsWidth: earliest-deadline pending channel.

Function
REQ-014 Config word: [OffsetWidth-1:0] offset, [24] ip, [25] ie, [26] trig (0 level, 1 rising edge), [28:27] state (read only).
REQ-015 Each channel SHALL run FSM IDLE -> PENDING -> INSERVICE -> IDLE.
REQ-016 IDLE->PENDING on trigger event with ie=1 (level: irq high; edge: irq high with registered previous irq low); timestamp := mtime_i (truncated to TsWidth).
REQ-017 PENDING->INSERVICE on claim_i with claim_id_i == channel; timestamp retained.
REQ-018 INSERVICE->IDLE on complete_i for that channel; if a pend-again condition holds (level: irq high; edge: pend_again flag set by a rising edge seen during INSERVICE) go directly to PENDING with timestamp := mtime_i of the completion cycle; pend_again cleared.
REQ-019 Claim of non-PENDING or complete of non-INSERVICE channel SHALL be ignored.
REQ-020 Config write SHALL update offset, ie, trig in the next cycle; ip=1 in IDLE -> PENDING with timestamp := mtime_i (software pend, regardless of ie); ip=0 in PENDING -> IDLE; ip ignored in INSERVICE.
REQ-021 Priority per channel per cycle: claim/complete > config ip > hardware trigger; offset/ie/trig writes always take effect.
REQ-022 Deadline = timestamp + zero-extended offset, saturating to all-ones on carry-out.
REQ-023 Selection over channels PENDING with ie=1: minimum deadline, ties to lowest index; registered, so best_* reflect state one cycle earlier (1-cycle latency).
REQ-024 best_id_o and best_dl_o SHALL be 0 when best_valid_o=0.
REQ-025 Read (cfg_req_i=1, cfg_we_i=0): cfg_rdata_o valid next cycle, held until next read; reserved bits 0.

Reset
REQ-026 On rst_i: all channels IDLE, timestamp/offset/ie/trig/pend_again/edge history 0, ip_o=is_o=0, best_valid_o=0, best_id_o=0, best_dl_o=0, cfg_rdata_o=0.
REQ-027 Reset mid-operation SHALL abort all pending/in-service state immediately; no event during reset is remembered.

Structure
REQ-028 Package edf_ic_pkg SHALL hold the channel-state enum, config bit positions, and the cfg word field constants.
REQ-029 Per-channel FSM, timestamp and deadline adder SHALL live in sub-module edf_gateway_ch, instantiated NumCh times; selection tree and cfg decode in the top.

Verification
REQ-030 ch3 offset=100, ie=1, level; irq[3] high at mtime=1000 -> ip_o[3]=1 next cycle, best_id_o=3, best_dl_o=1100 one cycle later.
REQ-031 ch1 dl=500, ch5 dl=500, ch2 dl=400 all pending -> best_id_o=2; claim ch2 -> best_id_o=1 (tie, lowest index).
REQ-032 ch0 edge mode claimed; rising edge during INSERVICE; complete at mtime=2000 -> ch0 PENDING, timestamp 2000, ip_o[0]=1.
REQ-033 timestamp=2^64-10, offset=50 -> best_dl_o=all-ones (saturation).
REQ-034 claim ch4 same cycle as cfg write ip=0 to ch4 -> ch4 INSERVICE; claim of IDLE ch6 -> no state change.
REQ-035 rst_i asserted while ch2 INSERVICE and ch7 PENDING -> all outputs 0 asynchronously; after release, level irq still high re-pends with new timestamp.
